pipe_fetch_stage: RTL and testbench

- IF stage of the five-stage pipelined MIPS core.
- Owns the PC register, a small branch target buffer (BTB) with 2-bit predictors, and the IF/ID pipeline register.
- Accepts stall from the hazard unit, plus redirect and predictor-update traffic from the branch/jump resolution logic downstream.
- No delay slot: every redirect squashes the younger fetched instruction.

---
 rtl/pipe_fetch_stage_pkg.sv | 25 ++
 rtl/pipe_fetch_stage_btb.sv | 79 +++++++
 rtl/pipe_fetch_stage.sv | 92 +++++++++
 tb/tb_pipe_fetch_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_fetch_stage_pkg.sv
// Shared definitions for the fetch stage and its branch target buffer.
//   - 2-bit predictor counter encodings and their reset value
//   - word-wide NOP constant
//   - ctr_next: saturating update of a 2-bit predictor counter
package pipe_fetch_stage_pkg;

   localparam logic [1:0]  CTR_SNT   = 2'b00;
   localparam logic [1:0]  CTR_WNT   = 2'b01;
   localparam logic [1:0]  CTR_WT    = 2'b10;
   localparam logic [1:0]  CTR_ST    = 2'b11;
   localparam logic [1:0]  CTR_RESET = CTR_WNT;

   localparam logic [31:0] NOP = 32'h0000_0000;

   function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
      logic [1:0] res;
      res = ctr;
      if (taken && ctr != CTR_ST)
         res = ctr + 2'b01;
      else if (!taken && ctr != CTR_SNT)
         res = ctr - 2'b01;
      return res;
   endfunction

endpackage

// File: rtl/pipe_fetch_stage_btb.sv
// branch_target_buffer: direct-mapped BTB with 2-bit predictors.
// Ports:
//   clk, reset_n     clock, synchronous active-low reset
//   lookup_word      fetch PC bits [31:2]
//   upd_valid        a resolved conditional branch trains the table
//   upd_word         resolved branch PC bits [31:2]
//   upd_taken        actual outcome
//   upd_target       actual target
//   hit              lookup entry valid with matching tag
//   pred_taken       hit and counter in a taken state
//   target           stored target of the looked-up entry
// Lookup reads the registered arrays, so a same-cycle update to the same
// index is only visible to the lookup on the following cycle.
module branch_target_buffer
   import pipe_fetch_stage_pkg::*;
#(
   parameter int BTB_ENTRIES = 16,
   parameter int BTB_IDX_W   = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [29:0] lookup_word,
   input  logic        upd_valid,
   input  logic [29:0] upd_word,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   output logic        hit,
   output logic        pred_taken,
   output logic [31:0] target
);

   localparam int TAG_W = 30 - BTB_IDX_W;

   logic             valid_q  [BTB_ENTRIES];
   logic [TAG_W-1:0] tag_q    [BTB_ENTRIES];
   logic [31:0]      target_q [BTB_ENTRIES];
   logic [1:0]       ctr_q    [BTB_ENTRIES];

   logic [BTB_IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0]     lk_tag;
   logic [BTB_IDX_W-1:0] up_idx;
   logic [TAG_W-1:0]     up_tag;
   logic                 up_hit;

   assign lk_idx = lookup_word[BTB_IDX_W-1:0];
   assign lk_tag = lookup_word[29:BTB_IDX_W];
   assign up_idx = upd_word[BTB_IDX_W-1:0];
   assign up_tag = upd_word[29:BTB_IDX_W];

   assign hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign pred_taken = hit && ctr_q[lk_idx][1];
   assign target     = target_q[lk_idx];

   assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CTR_RESET;
         end
      end else if (upd_valid) begin
         if (up_hit) begin
            ctr_q[up_idx] <= ctr_next(ctr_q[up_idx], upd_taken);
            if (upd_taken)
               target_q[up_idx] <= upd_target;
         end else if (upd_taken) begin
            // allocation evicts whatever entry occupied this index
            valid_q[up_idx]  <= 1'b1;
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= upd_target;
            ctr_q[up_idx]    <= CTR_WT;
         end
      end
   end

endmodule

// File: rtl/pipe_fetch_stage.sv
// pipe_fetch_stage: IF stage of the five-stage MIPS pipeline.
// Holds the PC, the next-PC priority mux (reset > redirect > stall > normal),
// the IF/ID pipeline register and a branch target buffer for prediction.
// Ports:
//   clk, reset_n           clock, synchronous active-low reset
//   stall                  hold PC and IF/ID
//   imemAddr / imemData    instruction memory (combinational read)
//   redirectValid/PC       squash the fetched instruction and refetch
//   updValid/PC/Taken/Target  BTB training from branch resolution
//   ifid*                  IF/ID register outputs
// No delay slot: a redirect always turns the IF/ID slot into a bubble.
module pipe_fetch_stage
   import pipe_fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          BTB_ENTRIES = 16,
   parameter int          BTB_IDX_W   = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall,
   output logic [31:0] imemAddr,
   input  logic [31:0] imemData,
   input  logic        redirectValid,
   input  logic [31:0] redirectPC,
   input  logic        updValid,
   input  logic [31:0] updPC,
   input  logic        updTaken,
   input  logic [31:0] updTarget,
   output logic        ifidValid,
   output logic [31:0] ifidInstr,
   output logic [31:0] ifidPC,
   output logic [31:0] ifidPCPlus4,
   output logic        ifidPredTaken,
   output logic [31:0] ifidPredTarget
);

   logic [31:0] pc_q;
   logic [31:0] pc_plus4;
   logic [31:0] next_seq;
   logic        btb_hit;
   logic        btb_pred_taken;
   logic [31:0] btb_target;
   logic        unused_bits;

   branch_target_buffer #(
      .BTB_ENTRIES (BTB_ENTRIES),
      .BTB_IDX_W   (BTB_IDX_W)
   ) u_btb (
      .clk         (clk),
      .reset_n     (reset_n),
      .lookup_word (pc_q[31:2]),
      .upd_valid   (updValid),
      .upd_word    (updPC[31:2]),
      .upd_taken   (updTaken),
      .upd_target  (updTarget),
      .hit         (btb_hit),
      .pred_taken  (btb_pred_taken),
      .target      (btb_target)
   );

   // byte-offset bits of the branch PC and the raw hit flag are not needed here
   assign unused_bits = ^{updPC[1:0], btb_hit};

   assign imemAddr = pc_q;
   assign pc_plus4 = pc_q + 32'd4;
   assign next_seq = btb_pred_taken ? btb_target : pc_plus4;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pc_q           <= RESET_PC;
         ifidValid      <= 1'b0;
         ifidInstr      <= NOP;
         ifidPC         <= '0;
         ifidPCPlus4    <= '0;
         ifidPredTaken  <= 1'b0;
         ifidPredTarget <= '0;
      end else if (redirectValid) begin
         pc_q      <= redirectPC;
         ifidValid <= 1'b0;
      end else if (!stall) begin
         pc_q           <= next_seq;
         ifidValid      <= 1'b1;
         ifidInstr      <= imemData;
         ifidPC         <= pc_q;
         ifidPCPlus4    <= pc_plus4;
         ifidPredTaken  <= btb_pred_taken;
         ifidPredTarget <= btb_pred_taken ? btb_target : 32'h0;
      end
   end

endmodule

// File: tb/tb_pipe_fetch_stage.sv
module tb_pipe_fetch_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        stall;
   logic [31:0] imemAddr;
   logic [31:0] imemData;
   logic        redirectValid;
   logic [31:0] redirectPC;
   logic        updValid;
   logic [31:0] updPC;
   logic        updTaken;
   logic [31:0] updTarget;
   logic        ifidValid;
   logic [31:0] ifidInstr;
   logic [31:0] ifidPC;
   logic [31:0] ifidPCPlus4;
   logic        ifidPredTaken;
   logic [31:0] ifidPredTarget;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_fetch_stage dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .stall          (stall),
      .imemAddr       (imemAddr),
      .imemData       (imemData),
      .redirectValid  (redirectValid),
      .redirectPC     (redirectPC),
      .updValid       (updValid),
      .updPC          (updPC),
      .updTaken       (updTaken),
      .updTarget      (updTarget),
      .ifidValid      (ifidValid),
      .ifidInstr      (ifidInstr),
      .ifidPC         (ifidPC),
      .ifidPCPlus4    (ifidPCPlus4),
      .ifidPredTaken  (ifidPredTaken),
      .ifidPredTarget (ifidPredTarget)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h2008_0001;
         32'h4:   return 32'h2009_0002;
         32'h8:   return 32'h200A_0003;
         default: return 32'hC000_0000 ^ a;
      endcase
   endfunction

   assign imemData = mem_word(imemAddr);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // one clock edge, then settle before sampling / driving
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      stall = 1'b0; redirectValid = 1'b0; redirectPC = '0;
      updValid = 1'b0; updPC = '0; updTaken = 1'b0; updTarget = '0;
   endtask

   task automatic redirect_to(input logic [31:0] a);
      redirectValid = 1'b1; redirectPC = a;
      tick;
      redirectValid = 1'b0;
   endtask

   task automatic btb_upd(input logic [31:0] a, input logic t, input logic [31:0] tgt);
      updValid = 1'b1; updPC = a; updTaken = t; updTarget = tgt;
      tick;
      updValid = 1'b0;
   endtask

   initial begin
      idle_inputs();
      reset_n = 1'b0;
      tick; tick;
      check("rst_addr",   imemAddr, 32'h0);
      check("rst_valid",  {31'b0, ifidValid}, 32'h0);
      check("rst_instr",  ifidInstr, 32'h0);
      check("rst_pc",     ifidPC, 32'h0);
      check("rst_pred",   {31'b0, ifidPredTaken}, 32'h0);
      reset_n = 1'b1;

      // sequential fetch
      tick;
      check("seq0_pc",    ifidPC, 32'h0);
      check("seq0_instr", ifidInstr, 32'h2008_0001);
      check("seq0_valid", {31'b0, ifidValid}, 32'h1);
      check("seq0_pred",  {31'b0, ifidPredTaken}, 32'h0);
      check("seq0_p4",    ifidPCPlus4, 32'h4);
      tick;
      check("seq1_pc",    ifidPC, 32'h4);
      check("seq1_instr", ifidInstr, 32'h2009_0002);
      check("seq1_addr",  imemAddr, 32'h8);

      // stall two cycles at PC = 0x8
      stall = 1'b1;
      tick; tick;
      check("stall_addr",  imemAddr, 32'h8);
      check("stall_pc",    ifidPC, 32'h4);
      check("stall_instr", ifidInstr, 32'h2009_0002);
      stall = 1'b0;
      tick;
      check("seq2_pc",    ifidPC, 32'h8);
      check("seq2_instr", ifidInstr, 32'h200A_0003);
      check("seq2_addr",  imemAddr, 32'hC);

      // redirect with concurrent stall
      stall = 1'b1;
      redirect_to(32'h40);
      stall = 1'b0;
      check("redir_addr",  imemAddr, 32'h40);
      check("redir_valid", {31'b0, ifidValid}, 32'h0);
      tick;
      check("redir_pc",    ifidPC, 32'h40);
      check("redir_v1",    {31'b0, ifidValid}, 32'h1);
      check("redir_instr", ifidInstr, 32'hC000_0040);

      // allocate 0x10 -> 0x100 and fetch it
      stall = 1'b1;
      btb_upd(32'h10, 1'b1, 32'h100);
      stall = 1'b0;
      redirect_to(32'h10);
      tick;
      check("alloc_pred", {31'b0, ifidPredTaken}, 32'h1);
      check("alloc_tgt",  ifidPredTarget, 32'h100);
      check("alloc_addr", imemAddr, 32'h100);

      // two not-taken updates: 10 -> 01 -> 00
      stall = 1'b1;
      btb_upd(32'h10, 1'b0, 32'h0);
      btb_upd(32'h10, 1'b0, 32'h0);
      check("nt_stall_addr", imemAddr, 32'h100);
      stall = 1'b0;
      redirect_to(32'h10);
      tick;
      check("nt_pred", {31'b0, ifidPredTaken}, 32'h0);
      check("nt_tgt",  ifidPredTarget, 32'h0);
      check("nt_addr", imemAddr, 32'h14);

      // retrain 00 -> 01 -> 10, then alias 0x50 to the same index
      stall = 1'b1;
      btb_upd(32'h10, 1'b1, 32'h180);
      btb_upd(32'h10, 1'b1, 32'h180);
      stall = 1'b0;
      redirect_to(32'h50);
      tick;
      check("alias_pred", {31'b0, ifidPredTaken}, 32'h0);
      check("alias_addr", imemAddr, 32'h54);

      // fetch 0x10 while a not-taken update lands: old counter (10) predicts
      redirect_to(32'h10);
      btb_upd(32'h10, 1'b0, 32'h0);
      check("rbw_pred", {31'b0, ifidPredTaken}, 32'h1);
      check("rbw_addr", imemAddr, 32'h180);
      redirect_to(32'h10);
      tick;
      check("rbw_after", {31'b0, ifidPredTaken}, 32'h0);

      // PC wraps modulo 2^32
      redirect_to(32'hFFFF_FFFC);
      tick;
      check("wrap_p4",   ifidPCPlus4, 32'h0);
      check("wrap_addr", imemAddr, 32'h0);

      // train to taken again (01 -> 10 -> 11) and confirm prediction
      stall = 1'b1;
      btb_upd(32'h10, 1'b1, 32'h200);
      btb_upd(32'h10, 1'b1, 32'h200);
      stall = 1'b0;
      redirect_to(32'h10);
      tick;
      check("pre_rst_pred", {31'b0, ifidPredTaken}, 32'h1);
      check("pre_rst_tgt",  ifidPredTarget, 32'h200);

      // reset during redirect + stall
      reset_n = 1'b0;
      stall = 1'b1;
      redirect_to(32'h300);
      stall = 1'b0;
      check("rst2_addr",  imemAddr, 32'h0);
      check("rst2_valid", {31'b0, ifidValid}, 32'h0);
      check("rst2_pc",    ifidPC, 32'h0);
      reset_n = 1'b1;
      redirect_to(32'h10);
      tick;
      check("rst2_pred", {31'b0, ifidPredTaken}, 32'h0);
      check("rst2_next", imemAddr, 32'h14);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
